// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// State encoding, bubble instruction and decode field positions.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int unsigned OPC_HI  = 31;
    localparam int unsigned OPC_LO  = 26;
    localparam int unsigned FUNC_HI = 5;
    localparam int unsigned FUNC_LO = 0;

    localparam int unsigned PC_INC  = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry buffer that parks a fetched instruction and its pc+4 while the
// IF/ID register is held by a downstream stall.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              unload,
    input  logic              flush,
    input  logic [31:0]       load_instr,
    input  logic [ADDR_W-1:0] load_pc4,
    output logic              valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc4
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc4   <= '0;
        end else if (flush || unload) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc4   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc4   <= load_pc4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID pipeline register with stall skid and branch squash.
// Defining FETCH_PERF_EN adds fetch/bubble performance counters.
//
// state | meaning
// FETCH | request outstanding at pc (or first cycle after reset, request rising)
// HOLD  | response parked in skid buffer, waiting for stall release; no request
// DRAIN | redirect pending, waiting for the in-flight response to be thrown away
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              if_id_valid,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic [5:0]        opcode,
    output logic [5:0]        func
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] redirect;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] target_al;

    logic              accept;
    logic              load_bubble;
    logic              skid_load;
    logic              skid_unload;
    logic              skid_flush;
    logic              skid_valid;
    logic [31:0]       skid_instr;
    logic [ADDR_W-1:0] skid_pc4;

    assign pc_next   = pc + ADDR_W'(PC_INC);
    assign target_al = branch_target & ~(ADDR_W'(3));
    assign imem_addr = pc;
    assign opcode    = if_id_instr[OPC_HI:OPC_LO];
    assign func      = if_id_instr[FUNC_HI:FUNC_LO];

    // A FETCH cycle with imem_req low is the post-reset ramp: nothing is in flight.
    always_comb begin
        accept      = 1'b0;
        load_bubble = 1'b0;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_flush  = 1'b0;
        case (state)
            FETCH: begin
                if (imem_req) begin
                    if (imem_ready && !branch_taken) begin
                        accept    = 1'b1;
                        skid_load = stall;
                    end else if (branch_taken || !stall) begin
                        load_bubble = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    skid_flush  = 1'b1;
                    load_bubble = 1'b1;
                end else if (!stall) begin
                    skid_unload = 1'b1;
                end
            end
            default: ;
        endcase
    end

    fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .unload     (skid_unload),
        .flush      (skid_flush),
        .load_instr (imem_rdata),
        .load_pc4   (pc_next),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc4        (skid_pc4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC[ADDR_W-1:0];
            redirect    <= '0;
            imem_req    <= 1'b0;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= '0;
        end else begin
            if (load_bubble) begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP_INSTR;
                if_id_pc4   <= '0;
            end
            case (state)
                FETCH: begin
                    imem_req <= 1'b1;
                    if (!imem_req) begin
                        if (branch_taken) pc <= target_al;
                    end else if (imem_ready) begin
                        if (branch_taken) begin
                            pc <= target_al;
                        end else begin
                            pc <= pc_next;
                            if (stall) begin
                                state    <= HOLD;
                                imem_req <= 1'b0;
                            end else begin
                                if_id_valid <= 1'b1;
                                if_id_instr <= imem_rdata;
                                if_id_pc4   <= pc_next;
                            end
                        end
                    end else if (branch_taken) begin
                        redirect <= target_al;
                        state    <= DRAIN;
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        pc       <= target_al;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end else if (!stall) begin
                        if_id_valid <= skid_valid;
                        if_id_instr <= skid_instr;
                        if_id_pc4   <= skid_pc4;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                    end
                end
                DRAIN: begin
                    // A redirect arriving in the same cycle as the response still wins.
                    if (branch_taken) redirect <= target_al;
                    if (imem_ready) begin
                        pc    <= branch_taken ? target_al : redirect;
                        state <= FETCH;
                    end
                end
                default: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (accept) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (load_bubble && !stall) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule
